// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: bus widths, default memory latency and the
// memory arbiter state encoding.
package cpu_pkg;

   localparam int PIPE_ADDR_W = 16;
   localparam int PIPE_DATA_W = 16;
   localparam int MEM_LAT_DEF = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BUSY_D = 3'd1,
      BUSY_I = 3'd2,
      DONE_D = 3'd3,
      DONE_I = 3'd4
   } arb_state_t;

   // Latency counter width; a one-cycle memory still needs a 1-bit counter.
   function automatic int cnt_width(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side and memory-side signals of the shared memory arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory view.
interface mem_arbiter_if
   import cpu_pkg::*;
#(
   parameter int ADDR_W = PIPE_ADDR_W,
   parameter int DATA_W = PIPE_DATA_W
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic [DATA_W-1:0] if_data;
   logic              if_valid;
   logic              if_stall;

   logic              d_req;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_valid;
   logic              d_stall;

   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, if_flush,
      input  d_req, d_wr, d_addr, d_wdata,
      input  mem_rdata,
      output if_data, if_valid, if_stall,
      output d_rdata, d_valid, d_stall,
      output mem_en, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, if_flush,
      output d_req, d_wr, d_addr, d_wdata,
      output mem_rdata,
      input  if_data, if_valid, if_stall,
      input  d_rdata, d_valid, d_stall,
      input  mem_en, mem_wr, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-ported unified memory between IF and MEM stages.
// Data has priority; after each completion the other requester claims first.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no access; grant D before I
//   BUSY_D | data access in flight, mem_en high for MEM_LAT cycles
//   BUSY_I | fetch in flight, mem_en high for MEM_LAT cycles
//   DONE_D | d_valid pulse; hand over to a waiting fetch
//   DONE_I | if_valid pulse unless flushed; hand over to a waiting data access
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = PIPE_ADDR_W,
   parameter int DATA_W  = PIPE_DATA_W,
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus
);

   localparam int               CNT_W    = cnt_width(MEM_LAT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   arb_state_t        state_q;
   arb_state_t        state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              flush_pend;

   logic              busy;
   logic              last;
   logic              grant_d;
   logic              grant_i;

   logic              mem_en_q;
   logic              mem_wr_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] if_data_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              if_valid_q;
   logic              d_valid_q;
   logic              if_valid_int;

   assign busy = (state_q == BUSY_D) || (state_q == BUSY_I);
   assign last = busy && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      grant_d = 1'b0;
      grant_i = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.d_req)       grant_d = 1'b1;
            else if (bus.if_req) grant_i = 1'b1;
         end
         BUSY_D: if (last) state_d = DONE_D;
         BUSY_I: if (last) state_d = DONE_I;
         // The finishing requester's req is stale here, so only the other one is looked at.
         DONE_D: begin
            state_d = IDLE;
            if (bus.if_req) grant_i = 1'b1;
         end
         DONE_I: begin
            state_d = IDLE;
            if (bus.d_req) grant_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (grant_d) state_d = BUSY_D;
      if (grant_i) state_d = BUSY_I;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         flush_pend  <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_data_q   <= '0;
         d_rdata_q   <= '0;
         if_valid_q  <= 1'b0;
         d_valid_q   <= 1'b0;
      end else begin
         state_q <= state_d;

         if (grant_d || grant_i || last) cnt_q <= '0;
         else if (busy)                  cnt_q <= cnt_q + CNT_W'(1);

         mem_en_q <= grant_d || grant_i || (busy && !last);

         if (grant_d) begin
            mem_wr_q    <= bus.d_wr;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
         end else if (grant_i) begin
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
         end else if (last) begin
            mem_wr_q    <= 1'b0;
         end

         if (last && state_q == BUSY_I) if_data_q <= bus.mem_rdata;
         if (last && state_q == BUSY_D && !mem_wr_q) d_rdata_q <= bus.mem_rdata;

         d_valid_q  <= last && (state_q == BUSY_D);
         if_valid_q <= last && (state_q == BUSY_I) && !flush_pend && !bus.if_flush;

         if (state_q == DONE_I)                       flush_pend <= 1'b0;
         else if (state_q == BUSY_I && bus.if_flush)  flush_pend <= 1'b1;
      end
   end

   // A flush arriving in the DONE_I cycle itself must still kill the pulse.
   assign if_valid_int = if_valid_q && !bus.if_flush;

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_data   = if_data_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.if_valid  = if_valid_int;
   assign bus.d_valid   = d_valid_q;
   assign bus.if_stall  = bus.if_req && !if_valid_int;
   assign bus.d_stall   = bus.d_req && !d_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written
// sequences for flush, starvation and mid-access reset.
module tb_mem_arbiter;
   import cpu_pkg::*;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ireq;
      logic [15:0] iaddr;
      logic        iflush;
      logic        dreq;
      logic        dwr;
      logic [15:0] daddr;
      logic [15:0] dwdata;
      logic [15:0] rdata;
      logic        en;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        ival;
      logic [15:0] idata;
      logic        dval;
      logic [15:0] drd;
      logic        istall;
      logic        dstall;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic ireq, input logic [15:0] iaddr, input logic iflush,
                      input logic dreq, input logic dwr, input logic [15:0] daddr,
                      input logic [15:0] dwdata, input logic [15:0] rdata,
                      input logic en, input logic wr, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic ival, input logic [15:0] idata,
                      input logic dval, input logic [15:0] drd,
                      input logic istall, input logic dstall);
      vec_t v;
      v.ireq = ireq; v.iaddr = iaddr; v.iflush = iflush; v.dreq = dreq; v.dwr = dwr;
      v.daddr = daddr; v.dwdata = dwdata; v.rdata = rdata; v.en = en; v.wr = wr;
      v.addr = addr; v.wdata = wdata; v.ival = ival; v.idata = idata; v.dval = dval;
      v.drd = drd; v.istall = istall; v.dstall = dstall;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int tag, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0d: got %h want %h", name, tag, act, exp);
      end
   endtask

   task automatic drive(input logic ireq, input logic [15:0] iaddr, input logic iflush,
                        input logic dreq, input logic dwr, input logic [15:0] daddr,
                        input logic [15:0] dwdata, input logic [15:0] rdata);
      bus.if_req    = ireq;
      bus.if_addr   = iaddr;
      bus.if_flush  = iflush;
      bus.d_req     = dreq;
      bus.d_wr      = dwr;
      bus.d_addr    = daddr;
      bus.d_wdata   = dwdata;
      bus.mem_rdata = rdata;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      drive(0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 16'h0);

      // lone fetch 0x0010 -> 0xA123
      add(1,'h10,0,0,0,'h0,'h0,'hA123, 0,0,'h00,'h0,0,'h0000,0,'h0000,1,0);
      for (int k = 0; k < 4; k++)
         add(1,'h10,0,0,0,'h0,'h0,'hA123, 1,0,'h10,'h0,0,'h0000,0,'h0000,1,0);
      add(1,'h10,0,0,0,'h0,'h0,'hA123, 0,0,'h10,'h0,1,'hA123,0,'h0000,0,0);
      add(0,'h10,0,0,0,'h0,'h0,'hA123, 0,0,'h10,'h0,0,'hA123,0,'h0000,0,0);
      // simultaneous: LW 0x0040 -> 0x1234 wins, then fetch 0x0030 -> 0x5678
      add(1,'h30,0,1,0,'h40,'h0,'h1234, 0,0,'h10,'h0,0,'hA123,0,'h0000,1,1);
      for (int k = 0; k < 4; k++)
         add(1,'h30,0,1,0,'h40,'h0,'h1234, 1,0,'h40,'h0,0,'hA123,0,'h0000,1,1);
      add(1,'h30,0,1,0,'h40,'h0,'h1234, 0,0,'h40,'h0,0,'hA123,1,'h1234,1,0);
      for (int k = 0; k < 4; k++)
         add(1,'h30,0,0,0,'h40,'h0,'h5678, 1,0,'h30,'h0,0,'hA123,0,'h1234,1,0);
      add(1,'h30,0,0,0,'h40,'h0,'h5678, 0,0,'h30,'h0,1,'h5678,0,'h1234,0,0);
      add(0,'h30,0,0,0,'h40,'h0,'h5678, 0,0,'h30,'h0,0,'h5678,0,'h1234,0,0);
      // SW 0x0042 <- 0xBEEF; read data bus must not reach d_rdata
      add(0,'h30,0,1,1,'h42,'hBEEF,'hDEAD, 0,0,'h30,'h0,0,'h5678,0,'h1234,0,1);
      for (int k = 0; k < 4; k++)
         add(0,'h30,0,1,1,'h42,'hBEEF,'hDEAD, 1,1,'h42,'hBEEF,0,'h5678,0,'h1234,0,1);
      add(0,'h30,0,1,1,'h42,'hBEEF,'hDEAD, 0,0,'h42,'hBEEF,0,'h5678,1,'h1234,0,0);
      add(0,'h30,0,0,1,'h42,'hBEEF,'hDEAD, 0,0,'h42,'hBEEF,0,'h5678,0,'h1234,0,0);

      // reset values
      #12;
      chk("rst_state", 0, 32'(dut.state_q), 32'(IDLE));
      chk("rst_en", 0, 32'(bus.mem_en), 32'h0);
      chk("rst_wr", 0, 32'(bus.mem_wr), 32'h0);
      chk("rst_addr", 0, 32'(bus.mem_addr), 32'h0);
      chk("rst_wdata", 0, 32'(bus.mem_wdata), 32'h0);
      chk("rst_ival", 0, 32'(bus.if_valid), 32'h0);
      chk("rst_dval", 0, 32'(bus.d_valid), 32'h0);
      chk("rst_idata", 0, 32'(bus.if_data), 32'h0);
      chk("rst_drd", 0, 32'(bus.d_rdata), 32'h0);
      chk("rst_cnt", 0, 32'(dut.cnt_q), 32'h0);
      chk("rst_fpend", 0, 32'(dut.flush_pend), 32'h0);
      #5 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].iflush, vecs[i].dreq, vecs[i].dwr,
               vecs[i].daddr, vecs[i].dwdata, vecs[i].rdata);
         @(negedge clk);
         chk("vec_en",     i, 32'(bus.mem_en),    32'(vecs[i].en));
         chk("vec_wr",     i, 32'(bus.mem_wr),    32'(vecs[i].wr));
         chk("vec_addr",   i, 32'(bus.mem_addr),  32'(vecs[i].addr));
         chk("vec_wdata",  i, 32'(bus.mem_wdata), 32'(vecs[i].wdata));
         chk("vec_ival",   i, 32'(bus.if_valid),  32'(vecs[i].ival));
         chk("vec_idata",  i, 32'(bus.if_data),   32'(vecs[i].idata));
         chk("vec_dval",   i, 32'(bus.d_valid),   32'(vecs[i].dval));
         chk("vec_drd",    i, 32'(bus.d_rdata),   32'(vecs[i].drd));
         chk("vec_istall", i, 32'(bus.if_stall),  32'(vecs[i].istall));
         chk("vec_dstall", i, 32'(bus.d_stall),   32'(vecs[i].dstall));
         @(posedge clk); #1;
      end

      // flush during fetch 0x0050; refetch 0x0020 granted in cycle 6
      for (int c = 0; c <= 12; c++) begin
         drive(c <= 11, (c >= 5) ? 16'h0020 : 16'h0050, c == 2, 0, 0, 16'h0, 16'h0,
               (c <= 5) ? 16'h1111 : 16'h2222);
         @(negedge clk);
         chk("fl_en", c, 32'(bus.mem_en), 32'((c >= 1 && c <= 4) || (c >= 7 && c <= 10)));
         chk("fl_ival", c, 32'(bus.if_valid), 32'(c == 11));
         if (c >= 1 && c <= 4) chk("fl_addr_a", c, 32'(bus.mem_addr), 32'h0050);
         if (c >= 7 && c <= 10) chk("fl_addr_b", c, 32'(bus.mem_addr), 32'h0020);
         if (c == 5) chk("fl_idata_a", c, 32'(bus.if_data), 32'h1111);
         if (c == 6) chk("fl_idle", c, 32'(dut.state_q), 32'(IDLE));
         if (c == 11) chk("fl_idata_b", c, 32'(bus.if_data), 32'h2222);
         @(posedge clk); #1;
      end

      // starvation: both held high; D first, then strict alternation every 5 cycles
      for (int c = 0; c <= 21; c++) begin
         drive(c <= 20, 16'h0070, 0, c < 20, 0, 16'h0080, 16'h0, 16'h4444);
         @(negedge clk);
         chk("sv_dval", c, 32'(bus.d_valid), 32'((c % 5 == 0) && ((c / 5) % 2 == 1)));
         chk("sv_ival", c, 32'(bus.if_valid), 32'((c % 5 == 0) && c > 0 && ((c / 5) % 2 == 0)));
         if (c == 21) chk("sv_idle", c, 32'(dut.state_q), 32'(IDLE));
         @(posedge clk); #1;
      end

      // reset in cycle 3 of a fetch
      drive(1, 16'h0060, 0, 0, 0, 16'h0, 16'h0, 16'h3333);
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
      end
      chk("rs_en_pre", 3, 32'(bus.mem_en), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("rs_en", 3, 32'(bus.mem_en), 32'h0);
      chk("rs_state", 3, 32'(dut.state_q), 32'(IDLE));
      for (int c = 4; c <= 6; c++) begin
         @(negedge clk);
         chk("rs_ival", c, 32'(bus.if_valid), 32'h0);
         chk("rs_en_hold", c, 32'(bus.mem_en), 32'h0);
      end
      @(posedge clk); #3;
      rst_n = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rs2_en", c, 32'(bus.mem_en), 32'(c <= 4));
         chk("rs2_ival", c, 32'(bus.if_valid), 32'(c == 5));
         if (c <= 4) chk("rs2_addr", c, 32'(bus.mem_addr), 32'h0060);
         if (c == 5) chk("rs2_idata", c, 32'(bus.if_data), 32'h3333);
      end
      #2 drive(0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
